// File: rtl/cct_frame_checker_if.sv
// cct_frame_checker_if: sample and result handshakes plus status outputs of the frame checker.
interface cct_frame_checker_if;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        result_ready;
    logic        result_valid;
    logic [15:0] sum_out;
    logic [7:0]  xor_out;
    logic [7:0]  max_out;
    logic [7:0]  frame_count;
    logic        busy;

    modport master (
        output sample_in, sample_valid, result_ready,
        input  sample_ready, result_valid, sum_out, xor_out, max_out, frame_count, busy
    );

    modport slave (
        input  sample_in, sample_valid, result_ready,
        output sample_ready, result_valid, sum_out, xor_out, max_out, frame_count, busy
    );
endinterface

// File: rtl/cct_frame_checker.sv
// cct_frame_checker: groups FRAME_LEN samples into frames and presents their sum, XOR and maximum.
module cct_frame_checker #(
    parameter int FRAME_LEN = 8
) (
    input logic               clk,
    input logic               clear_n,
    cct_frame_checker_if.slave bus
);
    localparam int IW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t        state_q, state_d;
    logic [15:0]   sum_q, sum_d, so_q, so_d;
    logic [7:0]    xor_q, xor_d, xo_q, xo_d;
    logic [7:0]    max_q, max_d, mo_q, mo_d;
    logic [7:0]    fc_q, fc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   sum_n;
    logic [7:0]    xor_n, max_n;
    logic          acc, last;

    // Accumulators sit at zero outside ACCUM, so the first sample needs no special load path.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        xor_d   = xor_q;
        max_d   = max_q;
        idx_d   = idx_q;
        so_d    = so_q;
        xo_d    = xo_q;
        mo_d    = mo_q;
        fc_d    = fc_q;
        acc     = bus.sample_valid && (state_q != HOLD);
        last    = (state_q == ACCUM) && (idx_q == IW'(FRAME_LEN - 1));
        sum_n   = sum_q + {8'd0, bus.sample_in};
        xor_n   = xor_q ^ bus.sample_in;
        max_n   = (max_q >= bus.sample_in) ? max_q : bus.sample_in;
        if (acc && last) begin
            state_d = HOLD;
            so_d    = sum_n;
            xo_d    = xor_n;
            mo_d    = max_n;
            sum_d   = '0;
            xor_d   = '0;
            max_d   = '0;
            idx_d   = '0;
        end else if (acc) begin
            state_d = ACCUM;
            sum_d   = sum_n;
            xor_d   = xor_n;
            max_d   = max_n;
            idx_d   = idx_q + IW'(1);
        end else if (state_q == HOLD && bus.result_ready) begin
            state_d = IDLE;
            fc_d    = fc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            xor_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            so_q    <= '0;
            xo_q    <= '0;
            mo_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            xor_q   <= xor_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            so_q    <= so_d;
            xo_q    <= xo_d;
            mo_q    <= mo_d;
            fc_q    <= fc_d;
        end
    end

    assign bus.sample_ready = (state_q != HOLD);
    assign bus.result_valid = (state_q == HOLD);
    assign bus.busy         = (state_q == ACCUM);
    assign bus.sum_out      = so_q;
    assign bus.xor_out      = xo_q;
    assign bus.max_out      = mo_q;
    assign bus.frame_count  = fc_q;
endmodule

// File: tb/tb_cct_frame_checker.sv
// tb_cct_frame_checker: directed and randomized frames checked against a per-frame arithmetic model.
module tb_cct_frame_checker;
    logic clk = 1'b0;
    logic clear_n;
    int   tests = 0;
    int   fails = 0;
    int   fc_exp = 0;
    logic [7:0] fr [8];

    always #5 clk = ~clk;

    cct_frame_checker_if a ();
    cct_frame_checker_if b ();

    cct_frame_checker #(.FRAME_LEN(8))   dut8   (.clk(clk), .clear_n(clear_n), .bus(a));
    cct_frame_checker #(.FRAME_LEN(256)) dut256 (.clk(clk), .clear_n(clear_n), .bus(b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input int maxgap, input int hold);
        int s, x, m, n;
        s = 0;
        x = 0;
        m = 0;
        a.result_ready = (hold == 0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                a.sample_valid = 1'b0;
                a.sample_in = 8'($urandom);
                @(negedge clk);
            end
            a.sample_in = fr[i];
            a.sample_valid = 1'b1;
            n = 0;
            while (!a.sample_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n == 50) check("accept_timeout", n, 0);
            @(negedge clk);
            a.sample_valid = 1'b0;
            a.sample_in = 8'($urandom);
            s += int'(fr[i]);
            x ^= int'(fr[i]);
            m = (int'(fr[i]) > m) ? int'(fr[i]) : m;
            if (i == 0) check("busy_first", a.busy, 1);
        end
        check("rv_rise", a.result_valid, 1);
        check("sum", a.sum_out, s);
        check("xor", a.xor_out, x);
        check("max", a.max_out, m);
        check("ready_hold", a.sample_ready, 0);
        check("busy_hold", a.busy, 0);
        repeat (hold) begin
            a.sample_valid = 1'b1;
            a.sample_in = 8'($urandom);
            @(negedge clk);
            check("bp_rv", a.result_valid, 1);
            check("bp_sum", a.sum_out, s);
            check("bp_max", a.max_out, m);
            check("bp_ready", a.sample_ready, 0);
        end
        a.sample_valid = 1'b0;
        a.result_ready = 1'b1;
        @(negedge clk);
        fc_exp = (fc_exp + 1) % 256;
        check("rv_fall", a.result_valid, 0);
        check("frame_count", a.frame_count, fc_exp);
        check("ready_back", a.sample_ready, 1);
        check("busy_idle", a.busy, 0);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
    endtask

    initial begin
        int s, x, m;
        clear_n = 1'b0;
        a.sample_valid = 1'b0;
        a.result_ready = 1'b0;
        a.sample_in = 8'd0;
        b.sample_valid = 1'b0;
        b.result_ready = 1'b0;
        b.sample_in = 8'd0;
        #12;
        check("rst_rv", a.result_valid, 0);
        check("rst_sum", a.sum_out, 0);
        check("rst_xor", a.xor_out, 0);
        check("rst_max", a.max_out, 0);
        check("rst_fc", a.frame_count, 0);
        check("rst_busy", a.busy, 0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("rel_ready", a.sample_ready, 1);
        check("rel_busy", a.busy, 0);

        for (int i = 0; i < 8; i++) fr[i] = 8'(i + 1);
        frame(0, 0);
        check("basic_fc_one", a.frame_count, 1);
        for (int i = 0; i < 8; i++) fr[i] = 8'hFF;
        frame(0, 0);
        rand_frame();
        frame(0, 5);
        frame(3, 0);
        rand_frame();
        frame(2, 3);

        for (int i = 0; i < 4; i++) begin
            a.sample_in = 8'($urandom);
            a.sample_valid = 1'b1;
            @(negedge clk);
        end
        a.sample_valid = 1'b0;
        check("mid_busy", a.busy, 1);
        #2 clear_n = 1'b0;
        #1;
        check("async_busy", a.busy, 0);
        check("async_fc", a.frame_count, 0);
        check("async_sum", a.sum_out, 0);
        check("async_ready", a.sample_ready, 1);
        @(negedge clk);
        clear_n = 1'b1;
        fc_exp = 0;
        rand_frame();
        frame(1, 0);

        repeat (257) begin
            rand_frame();
            frame(0, 0);
        end

        b.result_ready = 1'b1;
        b.sample_valid = 1'b1;
        b.sample_in = 8'hFF;
        repeat (256) @(negedge clk);
        b.sample_valid = 1'b0;
        check("f256_rv", b.result_valid, 1);
        check("f256_sum", b.sum_out, 16'hFF00);
        check("f256_xor", b.xor_out, 0);
        check("f256_max", b.max_out, 8'hFF);
        @(negedge clk);
        check("f256_fc", b.frame_count, 1);
        s = 0;
        x = 0;
        m = 0;
        b.sample_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b.sample_in = 8'($urandom);
            s += int'(b.sample_in);
            x ^= int'(b.sample_in);
            m = (int'(b.sample_in) > m) ? int'(b.sample_in) : m;
            @(negedge clk);
        end
        b.sample_valid = 1'b0;
        check("r256_rv", b.result_valid, 1);
        check("r256_sum", b.sum_out, s);
        check("r256_xor", b.xor_out, x);
        check("r256_max", b.max_out, m);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cct_frame_checker.md
# cct_frame_checker

Downstream consumer of the 8-bit `cct_output` stream produced by the student circuit. It accepts samples under a valid/ready handshake and groups them into frames of `FRAME_LEN` samples. For each frame it computes the sum, XOR and maximum, and presents them as one registered result under a second valid/ready handshake. It also keeps a wrapping count of delivered frames for the bench and scoreboard.

## Interface
- `FRAME_LEN`, default 8: samples per frame; legal range 2..256.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `clear_n`  input  1  asynchronous, active-low reset.
- `sample_in`  input  8  data sample (driven from upstream `cct_output`).
- `sample_valid`  input  1  `sample_in` is valid this cycle.
- `sample_ready`  output  1  block can accept a sample this cycle.
- `result_ready`  input  1  consumer accepts the presented result.
- `result_valid`  output  1  `sum_out`/`xor_out`/`max_out` hold a completed frame.
- `sum_out`  output  16  unsigned sum of the frame's samples, zero-extended.
- `xor_out`  output  8  bitwise XOR of the frame's samples.
- `max_out`  output  8  largest unsigned sample in the frame.
- `frame_count`  output  8  number of results delivered (handshakes completed), modulo 256.
- `busy`  output  1  a frame is partially accumulated.

## Operation
- Reset (`clear_n`=0, asynchronous, any time) forces:
  - state IDLE;
  - all accumulators, sample index, `sum_out`, `xor_out`, `max_out` and `frame_count` to 0;
  - `result_valid`=0 and `busy`=0;
  - `sample_ready`=1 once `clear_n` deasserts.
- A mid-frame or mid-HOLD reset discards the partial frame or pending result.
- A sample is accepted on a rising edge where `sample_valid` & `sample_ready`.
- `sample_ready` = (state != HOLD). It is a pure decode of registered state, with no path from `result_ready`.
- States:
  - IDLE: no samples held. An accept loads sum=`sample_in`, xor=`sample_in`, max=`sample_in` and index=1, then moves to ACCUM.
  - ACCUM (index 1..FRAME_LEN-1): an accept does sum+=`sample_in`, xor^=`sample_in`, max=max(max,`sample_in`) and index+=1.
    - When the accept is the FRAME_LEN-th sample, the final values are written into `sum_out`/`xor_out`/`max_out` on that same edge. `result_valid` is set to 1 and the state moves to HOLD; the accumulators and index are cleared.
  - HOLD: outputs are frozen and samples are not accepted.
    - On an edge with `result_ready`=1: `result_valid`→0, `frame_count`+=1 (255→0 wrap), state→IDLE.
- Arithmetic:
  - The sum accumulator is 16 bits and the operand is zero-extended. The maximum frame sum is 256×255 = 65280, so no overflow.
  - Max comparison is unsigned. Ties keep the existing value, which is the same value.
- `busy` = (state == ACCUM).
- `sample_valid` with no accept (in HOLD) has no effect. The upstream must hold the sample.
- `result_ready` outside HOLD is ignored.
- X on `sample_in` while `sample_valid`=0 must not propagate into the accumulators.

## Timing
- All outputs are registered or are decodes of registered state.
- Latency: `result_valid` rises at the clock edge that accepts the last sample of a frame.
- With `result_ready` held high, HOLD lasts exactly 1 cycle. The peak rate is therefore FRAME_LEN samples per FRAME_LEN+1 cycles.
- `sample_ready` returns to 1 the cycle after the result handshake edge.
- The first sample of the next frame can be accepted on the edge following the handshake edge.
- Back-to-back samples in ACCUM are accepted every cycle with no bubbles.
- `frame_count` updates on the handshake edge, in the same cycle that `result_valid` falls.

## Test plan
- Reset values: drive `clear_n`=0 → all outputs 0 except `sample_ready`; after release `sample_ready`=1 and `busy`=0.
- Basic frame: FRAME_LEN=8, samples 0x01..0x08 on consecutive cycles, `result_ready`=1 → `result_valid` for 1 cycle with `sum_out`=0x0024, `xor_out`=0x08, `max_out`=0x08; then `frame_count`=1.
- Saturation width: eight samples of 0xFF → `sum_out`=0x07F8, `xor_out`=0x00, `max_out`=0xFF. With FRAME_LEN=256, all 0xFF → `sum_out`=0xFF00.
- Backpressure:
  - hold `result_ready`=0 for 5 cycles after frame completion → outputs stable, `sample_ready`=0, and a `sample_valid` pulse is not accepted;
  - raise `result_ready` → handshake, and the next frame starts fresh.
- Bubbles and async reset:
  - samples with `sample_valid` gaps → same result as without gaps;
  - assert `clear_n`=0 between clock edges after 4 of 8 samples → immediate clear, and the subsequent full frame computes only its own samples.
- Wrap: deliver 256 frames → `frame_count` goes 0xFF→0x00.
